// File: rtl/control_fsm_pkg.sv
// control_fsm_pkg: shared state encoding and instruction constants
package control_fsm_pkg;
    typedef enum logic [2:0] {BOOT, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW = 2'b01;
    localparam logic [1:0] OP_SW = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;
    localparam logic [5:0] HALT_OFFSET = 6'h3F;
endpackage

// File: rtl/control_fsm_instr_decode.sv
// instr_decode: splits the instruction register into fields, immediate and halt flag
module instr_decode
    import control_fsm_pkg::*;
(
    input  logic [7:0] ir,
    output logic [1:0] op,
    output logic [1:0] rs,
    output logic [1:0] rt,
    output logic [1:0] rd,
    output logic [7:0] imm,
    output logic       is_halt
);
    assign op = ir[7:6];
    assign rs = ir[5:4];
    assign rt = ir[3:2];
    assign rd = ir[1:0];
    assign imm = {{6{ir[1]}}, ir[1:0]};
    assign is_halt = op == OP_JMP && ir[5:0] == HALT_OFFSET;
endmodule

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle Moore controller sequencing fetch, decode, execute, memory and writeback
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       CLK,
    input  logic       areset,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ack,
    input  logic [7:0] imem_data,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic [1:0] sel_a,
    output logic [1:0] sel_b,
    output logic [1:0] sel_e,
    output logic       write_bit,
    output logic       wb_src,
    output logic       alu_b_src,
    output logic [7:0] imm,
    output logic       halted
);
    state_t     state, state_n;
    logic [7:0] pc, pc_n, ir, ir_n;
    logic [1:0] op, rs, rt, rd;
    logic       is_halt;

    instr_decode u_dec (
        .ir(ir), .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .is_halt(is_halt)
    );

    always_ff @(posedge CLK or posedge areset) begin
        if (areset) begin
            state <= BOOT;
            pc <= RESET_PC;
            ir <= 8'h00;
        end else begin
            state <= state_n;
            pc <= pc_n;
            ir <= ir_n;
        end
    end

    assign imem_addr = pc;

    always_comb begin
        state_n = state;
        pc_n = pc;
        ir_n = ir;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we = 1'b0;
        sel_a = 2'b00;
        sel_b = 2'b00;
        sel_e = 2'b00;
        write_bit = 1'b0;
        wb_src = 1'b0;
        alu_b_src = 1'b0;
        halted = 1'b0;
        unique case (state)
            BOOT: state_n = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_n = imem_data;
                    state_n = DECODE;
                end
            end
            DECODE: begin
                sel_a = rs;
                sel_b = rt;
                if (is_halt) begin
                    state_n = HALT;
                end else if (op == OP_JMP) begin
                    pc_n = pc + 8'd1 + {{2{ir[5]}}, ir[5:0]};
                    state_n = FETCH;
                end else begin
                    state_n = EXEC;
                end
            end
            EXEC: begin
                sel_a = rs;
                sel_b = rt;
                if (op == OP_ADD) begin
                    write_bit = 1'b1;
                    sel_e = rd;
                    pc_n = pc + 8'd1;
                    state_n = FETCH;
                end else begin
                    alu_b_src = 1'b1;
                    state_n = MEM;
                end
            end
            MEM: begin
                sel_a = rs;
                sel_b = rt;
                dmem_req = 1'b1;
                dmem_we = op == OP_SW;
                alu_b_src = 1'b1;
                if (dmem_ack) begin
                    // stores retire here; loads still need the writeback cycle
                    pc_n = op == OP_SW ? pc + 8'd1 : pc;
                    state_n = op == OP_SW ? FETCH : WB;
                end
            end
            WB: begin
                sel_a = rs;
                sel_b = rt;
                write_bit = 1'b1;
                sel_e = rt;
                wb_src = 1'b1;
                pc_n = pc + 8'd1;
                state_n = FETCH;
            end
            HALT: halted = 1'b1;
            default: state_n = BOOT;
        endcase
    end
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed self-checking bench for control_fsm
module tb_control_fsm;
    logic       CLK = 1'b0, areset = 1'b1, imem_ack = 1'b0, dmem_ack = 1'b0;
    logic [7:0] imem_data = 8'h00;
    logic       imem_req, dmem_req, dmem_we, write_bit, wb_src, alu_b_src, halted;
    logic [7:0] imem_addr, imm;
    logic [1:0] sel_a, sel_b, sel_e;
    int         checks = 0, failures = 0;

    control_fsm #(.RESET_PC(8'h00)) dut (
        .CLK(CLK), .areset(areset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .sel_a(sel_a), .sel_b(sel_b), .sel_e(sel_e),
        .write_bit(write_bit), .wb_src(wb_src), .alu_b_src(alu_b_src),
        .imm(imm), .halted(halted)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic fetch(input logic [7:0] d);
        chk("fetch_req", imem_req, 1);
        imem_ack = 1'b1;
        imem_data = d;
        step();
        imem_ack = 1'b0;
        imem_data = 8'hA5;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        imem_data = 8'h77;
        step();
        step();
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 8'h00);
        chk("rst_imm", imm, 8'h00);
        chk("rst_halted", halted, 0);
        chk("rst_write_bit", write_bit, 0);
        chk("rst_dmem_req", dmem_req, 0);
        areset = 1'b0;
        chk("boot_no_req", imem_req, 0);
        step();
        // ADD 0x06 acked on the third FETCH cycle
        chk("fetch1_req", imem_req, 1);
        chk("fetch1_addr", imem_addr, 8'h00);
        step();
        chk("fetch2_req", imem_req, 1);
        step();
        fetch(8'h06);
        chk("add_dec_req", imem_req, 0);
        chk("add_dec_wr", write_bit, 0);
        chk("add_dec_sel_a", sel_a, 0);
        chk("add_dec_sel_b", sel_b, 1);
        step();
        chk("add_ex_wr", write_bit, 1);
        chk("add_ex_sel_e", sel_e, 2);
        chk("add_ex_sel_a", sel_a, 0);
        chk("add_ex_sel_b", sel_b, 1);
        chk("add_ex_wb_src", wb_src, 0);
        chk("add_ex_alu_b", alu_b_src, 0);
        step();
        chk("add_done_wr", write_bit, 0);
        chk("add_next_addr", imem_addr, 8'h01);
        // LW 0x4B with four stalled memory cycles
        fetch(8'h4B);
        chk("lw_imm", imm, 8'hFF);
        step();
        chk("lw_ex_alu_b", alu_b_src, 1);
        chk("lw_ex_dreq", dmem_req, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("lw_mem_dreq", dmem_req, 1);
            chk("lw_mem_we", dmem_we, 0);
            chk("lw_mem_alu_b", alu_b_src, 1);
            chk("lw_mem_wr", write_bit, 0);
            step();
        end
        chk("lw_mem5_dreq", dmem_req, 1);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("lw_wb_wr", write_bit, 1);
        chk("lw_wb_sel_e", sel_e, 2);
        chk("lw_wb_src", wb_src, 1);
        chk("lw_wb_dreq", dmem_req, 0);
        step();
        chk("lw_done_wr", write_bit, 0);
        chk("lw_next_addr", imem_addr, 8'h02);
        // SW 0x8D acked on the first request cycle
        fetch(8'h8D);
        chk("sw_imm", imm, 8'h01);
        chk("sw_dec_sel_b", sel_b, 3);
        step();
        chk("sw_ex_alu_b", alu_b_src, 1);
        step();
        chk("sw_mem_dreq", dmem_req, 1);
        chk("sw_mem_we", dmem_we, 1);
        chk("sw_mem_sel_b", sel_b, 3);
        chk("sw_mem_alu_b", alu_b_src, 1);
        chk("sw_mem_wr", write_bit, 0);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("sw_done_wr", write_bit, 0);
        chk("sw_next_addr", imem_addr, 8'h03);
        // two ADDs to reach pc=0x05, with a stray dmem_ack that must be ignored
        for (int i = 0; i < 2; i++) begin
            fetch(8'h00);
            dmem_ack = 1'b1;
            step();
            dmem_ack = 1'b0;
            chk("pad_add_dreq", dmem_req, 0);
            step();
        end
        chk("pre_jmp_addr", imem_addr, 8'h05);
        fetch(8'hC2);
        chk("jmp_dec_wr", write_bit, 0);
        step();
        chk("jmp_target", imem_addr, 8'h08);
        fetch(8'hF6);
        step();
        chk("jmp_back_target", imem_addr, 8'hFF);
        fetch(8'h00);
        step();
        step();
        chk("pc_wrap_addr", imem_addr, 8'h00);
        fetch(8'hFE);
        step();
        chk("jmp_wrap_target", imem_addr, 8'hFF);
        // HALT with acks hammering the inputs
        fetch(8'hFF);
        chk("halt_dec_halted", halted, 0);
        step();
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("halt_halted", halted, 1);
            chk("halt_ireq", imem_req, 0);
            chk("halt_dreq", dmem_req, 0);
            chk("halt_wr", write_bit, 0);
            chk("halt_pc", imem_addr, 8'hFF);
            step();
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        // reset pulsed while a load waits for its ack
        areset = 1'b1;
        step();
        areset = 1'b0;
        step();
        fetch(8'hC4);
        step();
        chk("pre_lw_addr", imem_addr, 8'h05);
        fetch(8'h40);
        step();
        step();
        chk("midrst_dreq_before", dmem_req, 1);
        #2 areset = 1'b1;
        #1;
        chk("midrst_dreq_async", dmem_req, 0);
        chk("midrst_pc", imem_addr, 8'h00);
        chk("midrst_ireq", imem_req, 0);
        step();
        chk("midrst_hold_ireq", imem_req, 0);
        areset = 1'b0;
        chk("midrst_boot_ireq", imem_req, 0);
        step();
        chk("midrst_fetch_ireq", imem_req, 1);
        chk("midrst_fetch_addr", imem_addr, 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 8'h00, which is the PC value loaded by reset.
REQ-002 The block SHALL have port CLK  in  1  system clock; all state changes on posedge.
REQ-003 The block SHALL have port areset  in  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have ports imem_req out 1, imem_addr out 8, imem_ack in 1 and imem_data in 8: the instruction fetch handshake.
REQ-005 The block SHALL have ports dmem_req out 1, dmem_we out 1 and dmem_ack in 1: the data access handshake, where dmem_we=1 means store.
REQ-006 The block SHALL have ports sel_a, sel_b and sel_e, each out 2: register-file read A, read B and write selectors.
REQ-007 The block SHALL have port write_bit  out  1  register-file write enable.
REQ-008 The block SHALL have ports wb_src out 1 (0=ALU, 1=memory), alu_b_src out 1 (0=regB, 1=imm) and imm out 8 (sign-extended immediate).
REQ-009 The block SHALL have port halted  out  1  processor stopped.

Function
REQ-010 Instruction format SHALL be [7:6] op, [5:4] rs, [3:2] rt, [1:0] rd/imm2.
REQ-011 Op codes SHALL be: 00 ADD (rd=rs+rt); 01 LW (rt=mem[rs+imm]); 10 SW (mem[rs+imm]=rt); 11 JMP (pc=pc+1+sext(IR[5:0])).
REQ-012 JMP with IR[5:0]=6'h3F SHALL be HALT; imm SHALL equal sext(IR[1:0]) to 8 bits at all times.
REQ-013 States SHALL be BOOT, FETCH, DECODE, EXEC, MEM, WB and HALT; all outputs are decoded from state and IR (Moore).
REQ-014 BOOT: all requests low; the FSM SHALL go to FETCH on the next clock.
REQ-015 FETCH: imem_req=1 and imem_addr=pc held stable until imem_ack is sampled high; on that edge IR<=imem_data and the FSM goes to DECODE.
REQ-016 imem_req SHALL be low in every state other than FETCH.
REQ-017 DECODE (1 cycle), for JMP: pc<=pc+1+sext(IR[5:0]) and the FSM goes to FETCH.
REQ-018 DECODE, for HALT: the FSM goes to HALT and pc is unchanged.
REQ-019 DECODE, for ADD, LW and SW: the FSM goes to EXEC.
REQ-020 From DECODE until the instruction retires, sel_a SHALL equal IR[5:4] and sel_b SHALL equal IR[3:2].
REQ-021 EXEC, ADD: write_bit=1, sel_e=IR[1:0], wb_src=0, alu_b_src=0, pc<=pc+1, next state FETCH; total latency is FETCH+2 cycles.
REQ-022 EXEC, LW/SW: alu_b_src=1 and the FSM goes to MEM.
REQ-023 MEM: dmem_req=1, dmem_we=(op==SW) and alu_b_src=1 held until dmem_ack is sampled high.
REQ-024 MEM on ack, LW: next state WB.
REQ-025 MEM on ack, SW: pc<=pc+1 and next state FETCH; for SW, sel_b (=rt) supplies the store data.
REQ-026 WB (LW only): write_bit=1, sel_e=IR[3:2], wb_src=1, pc<=pc+1, next state FETCH.
REQ-027 Data memory SHALL hold read data until its next request; this block does not latch load data.
REQ-028 write_bit SHALL be high only in EXEC(ADD) and WB, for exactly one cycle per instruction; for SW, JMP and HALT it stays 0.
REQ-029 PC arithmetic SHALL be modulo 256: 0xFF+1=0x00, and jump targets wrap.
REQ-030 Ack inputs outside their wait state SHALL be ignored; an ack on the first request cycle SHALL complete the access that cycle.
REQ-031 HALT: halted=1, all requests and write_bit low, exit only by reset.

Reset
REQ-032 While areset is high, state=BOOT, pc=RESET_PC and IR=0; all outputs 0 except imem_addr=RESET_PC and imm=0.
REQ-033 An areset asserted mid-access SHALL drop imem_req/dmem_req immediately, without waiting for a clock.
REQ-034 After areset release, the first imem_req SHALL rise one cycle later (BOOT→FETCH).

Structure
REQ-035 The shared package SHALL hold the state enumeration, the opcode constants (OP_ADD, OP_LW, OP_SW, OP_JMP) and HALT_OFFSET=6'h3F.
REQ-036 One combinational sub-module, instr_decode, SHALL split IR into op/rs/rt/rd, imm and is_halt.

Verification
REQ-037 Reset, then imem_ack on the 3rd FETCH cycle with data 0x06 -> one write_bit pulse with sel_e=2, sel_a=0, sel_b=1, wb_src=0; next imem_addr=0x01.
REQ-038 LW 0x4B -> imm=0xFF; dmem_req=1 and dmem_we=0 held through 4 no-ack cycles; after ack, one WB cycle with write_bit=1, sel_e=2, wb_src=1.
REQ-039 SW 0x8D -> dmem_we=1, sel_b=3, imm=0x01, alu_b_src=1; write_bit stays 0; pc increments by 1.
REQ-040 At pc=0x05, JMP 0xC2 -> next imem_addr=0x08.
REQ-041 At pc=0xFF, ADD -> next imem_addr=0x00.
REQ-042 HALT 0xFF -> halted=1, pc unchanged, no req or write_bit for 20 cycles.
REQ-043 areset pulsed while in MEM awaiting ack -> dmem_req low in the same cycle, pc=RESET_PC, BOOT then FETCH.
